spi_master: RTL and testbench

//  FPGA-side SPI master for the sample link. Drives sck/sdo and captures sdi
//  to move one WIDTH-bit word per frame, MSB first, in SPI mode 0
//  (CPOL=0, CPHA=0). Used to exercise or feed spi_slave-style endpoints,
//  for example to push filter coefficients or read back voltage samples.

---
 rtl/spi_master_pkg.sv | 8 +
 rtl/spi_master_if.sv | 28 ++
 rtl/spi_master_clk_div.sv | 37 +++
 rtl/spi_master.sv | 152 +++++++++++++++
 tb/tb_spi_master.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/spi_master_pkg.sv
// Shared types and constants for the SPI master slice.
package spi_pkg;

  localparam int unsigned SPI_WORD = 32;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, GAP} spi_state_t;

endpackage

// File: rtl/spi_master_if.sv
// Handshake and SPI pin bundle between the SPI master and its user/peer.
interface spi_master_if
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH = SPI_WORD
);

  logic             start;
  logic [WIDTH-1:0] tx_data;
  logic             ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             sck;
  logic             sdo;
  logic             sdi;
  logic             ss_n;

  modport master (
    input  start, tx_data, sdi,
    output ready, rx_data, rx_valid, sck, sdo, ss_n
  );

  modport slave (
    output start, tx_data, sdi,
    input  ready, rx_data, rx_valid, sck, sdo, ss_n
  );

endinterface

// File: rtl/spi_master_clk_div.sv
// Half-period counter: tick marks the last clk cycle of each sck phase.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = $clog2(CLK_DIV + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == CW'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr || tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: one WIDTH-bit word per frame, MSB first, sdi sampled at sck fall.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH    = SPI_WORD,
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned IDLE_GAP = 2
) (
  input logic          clk,
  input logic          reset,
  spi_master_if.master bus
);

  localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned GW = $clog2(IDLE_GAP + 1);

  spi_state_t       state_q, state_d;
  logic             sck_q, sck_d;
  logic             sdo_q, sdo_d;
  logic             ss_n_q, ss_n_d;
  logic             rx_valid_q, rx_valid_d;
  logic [WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [GW-1:0]    gap_q, gap_d;

  logic             half_tick;
  logic             div_en;
  logic             div_clr;
  logic             gap_last;
  logic             last_bit;
  logic             ready_w;
  logic             accept;
  logic [WIDTH-1:0] tx_sh;
  logic [WIDTH-1:0] rx_sh;

  assign div_en  = (state_q == LOW) || (state_q == HIGH);
  assign div_clr = (state_q == IDLE) || (state_q == GAP);

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk   (clk),
    .reset (reset),
    .en    (div_en),
    .clr   (div_clr),
    .tick  (half_tick)
  );

  // Ready also covers the final GAP cycle so a held start re-accepts exactly
  // IDLE_GAP cycles after ss_n rises.
  assign gap_last = (state_q == GAP) && (gap_q == GW'(IDLE_GAP - 1));
  assign ready_w  = (state_q == IDLE) || gap_last;
  assign accept   = bus.start && ready_w;
  assign last_bit = (bit_q == BW'(WIDTH - 1));
  assign tx_sh    = tx_sr_q << 1;
  assign rx_sh    = (rx_sr_q << 1) | WIDTH'(bus.sdi);

  always_comb begin
    state_d    = state_q;
    sck_d      = sck_q;
    sdo_d      = sdo_q;
    ss_n_d     = ss_n_q;
    rx_valid_d = 1'b0;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    bit_d      = bit_q;
    gap_d      = gap_q;

    unique case (state_q)
      IDLE: ;
      LOW: begin
        if (half_tick) begin
          sck_d   = 1'b1;
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (half_tick) begin
          sck_d   = 1'b0;
          rx_sr_d = rx_sh;
          if (last_bit) begin
            rx_data_d  = rx_sh;
            rx_valid_d = 1'b1;
            ss_n_d     = 1'b1;
            sdo_d      = 1'b0;
            gap_d      = '0;
            state_d    = GAP;
          end else begin
            tx_sr_d = tx_sh;
            sdo_d   = tx_sh[WIDTH-1];
            bit_d   = bit_q + BW'(1);
            state_d = LOW;
          end
        end
      end
      GAP: begin
        if (gap_last) begin
          gap_d   = '0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      tx_sr_d = bus.tx_data;
      sdo_d   = bus.tx_data[WIDTH-1];
      ss_n_d  = 1'b0;
      rx_sr_d = '0;
      bit_d   = '0;
      gap_d   = '0;
      state_d = LOW;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      sck_q      <= 1'b0;
      sdo_q      <= 1'b0;
      ss_n_q     <= 1'b1;
      rx_valid_q <= 1'b0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      bit_q      <= '0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      sck_q      <= sck_d;
      sdo_q      <= sdo_d;
      ss_n_q     <= ss_n_d;
      rx_valid_q <= rx_valid_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      bit_q      <= bit_d;
      gap_q      <= gap_d;
    end
  end

  assign bus.ready    = ready_w;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.sck      = sck_q;
  assign bus.sdo      = sdo_q;
  assign bus.ss_n     = ss_n_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: vector table of frames plus hand-written corner sequences.
module tb_spi_master;

  localparam int GAP = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_master_if #(.WIDTH(32)) b0 ();
  spi_master_if #(.WIDTH(32)) b1 ();

  spi_master #(.WIDTH(32), .CLK_DIV(2), .IDLE_GAP(GAP)) dut0 (
    .clk   (clk),
    .reset (rst_n),
    .bus   (b0.master)
  );

  spi_master #(.WIDTH(32), .CLK_DIV(1), .IDLE_GAP(GAP)) dut1 (
    .clk   (clk),
    .reset (rst_n),
    .bus   (b1.master)
  );

  // Bench mode-0 slave on dut0: shifts d out on sck fall, captures sdo on sck rise.
  logic        loop0 = 1'b1;
  logic [31:0] s_d   = '0;
  logic [4:0]  s_cnt = '0;
  logic [31:0] s_q   = '0;

  always @(negedge b0.sck or posedge b0.ss_n) begin
    if (b0.ss_n) s_cnt <= '0;
    else         s_cnt <= s_cnt + 5'd1;
  end

  always @(posedge b0.sck) s_q <= {s_q[30:0], b0.sdo};

  assign b0.sdi = loop0 ? b0.sdo : s_d[5'd31 - s_cnt];
  assign b1.sdi = b1.sdo;

  logic        sel = 1'b0;
  logic        m_ready, m_valid, m_sck, m_ss_n;
  logic [31:0] m_rx;
  assign m_ready = sel ? b1.ready    : b0.ready;
  assign m_valid = sel ? b1.rx_valid : b0.rx_valid;
  assign m_sck   = sel ? b1.sck      : b0.sck;
  assign m_ss_n  = sel ? b1.ss_n     : b0.ss_n;
  assign m_rx    = sel ? b1.rx_data  : b0.rx_data;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [31:0] tx);
    if (sel) begin
      b1.start   = s;
      b1.tx_data = tx;
    end else begin
      b0.start   = s;
      b0.tx_data = tx;
    end
  endtask

  typedef struct {
    logic [31:0] rx;
    int          valid_k;
    int          nvalid;
    int          nrise;
    logic        ssn_pre;
    logic        ssn_v;
    logic        rdy_v;
    logic        rdy_g;
    logic        rs_sck;
    logic        rs_ssn;
    logic        rs_rdy;
    logic [31:0] rs_rx;
  } res_t;

  // k counts posedges after E0; each sample is taken on the following negedge.
  task automatic frame(input logic [31:0] tx, input int budget, input int poke_k,
                       input int rst_k, output res_t r);
    logic prev;
    logic last_ssn;
    r.rx = '0; r.valid_k = -1; r.nvalid = 0; r.nrise = 0;
    r.ssn_pre = 1'bx; r.ssn_v = 1'bx; r.rdy_v = 1'bx; r.rdy_g = 1'bx;
    r.rs_sck = 1'bx; r.rs_ssn = 1'bx; r.rs_rdy = 1'bx; r.rs_rx = 'x;
    @(negedge clk);
    drive(1'b1, tx);
    @(negedge clk);
    drive(1'b0, ~tx);
    prev     = m_sck;
    last_ssn = m_ss_n;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (m_sck && !prev) r.nrise++;
      prev = m_sck;
      if (m_valid) begin
        r.nvalid++;
        if (r.valid_k < 0) begin
          r.valid_k = k;
          r.rx      = m_rx;
          r.rdy_v   = m_ready;
          r.ssn_v   = m_ss_n;
          r.ssn_pre = last_ssn;
        end
      end
      last_ssn = m_ss_n;
      if (r.valid_k > 0 && k == r.valid_k + GAP) r.rdy_g = m_ready;
      if (k == rst_k + 1) begin
        r.rs_sck = m_sck;
        r.rs_ssn = m_ss_n;
        r.rs_rdy = m_ready;
        r.rs_rx  = m_rx;
        rst_n    = 1'b1;
      end
      if (k == poke_k)     drive(1'b1, 32'hFFFF_FFFF);
      if (k == poke_k + 1) drive(1'b0, ~tx);
      if (k == rst_k)      rst_n = 1'b0;
    end
  endtask

  typedef struct {
    logic [31:0] tx;
    logic [31:0] d;
    logic        loop;
    logic [31:0] exp_rx;
    logic [31:0] exp_q;
  } vec_t;

  vec_t vecs[5];

  initial begin
    res_t        r;
    int          e0b, nhigh, nv, v2k;
    logic [31:0] rx1, rx2;

    vecs[0] = '{32'hA5A5_0F0F, 32'h0000_0000, 1'b1, 32'hA5A5_0F0F, 32'hA5A5_0F0F};
    vecs[1] = '{32'h1234_5678, 32'h0000_03FF, 1'b0, 32'h0000_03FF, 32'h1234_5678};
    vecs[2] = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[3] = '{32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 32'h8000_0001, 32'hFFFF_FFFF};
    vecs[4] = '{32'h8000_0001, 32'h0000_0000, 1'b1, 32'h8000_0001, 32'h8000_0001};

    b0.start = 1'b0; b0.tx_data = '0;
    b1.start = 1'b0; b1.tx_data = '0;
    repeat (3) @(negedge clk);
    check("rst_sck",      {31'd0, b0.sck},      32'd0);
    check("rst_sdo",      {31'd0, b0.sdo},      32'd0);
    check("rst_ss_n",     {31'd0, b0.ss_n},     32'd1);
    check("rst_ready",    {31'd0, b0.ready},    32'd1);
    check("rst_rx_valid", {31'd0, b0.rx_valid}, 32'd0);
    check("rst_rx_data",  b0.rx_data,           32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      loop0 = vecs[i].loop;
      s_d   = vecs[i].d;
      frame(vecs[i].tx, 2*2*32 + GAP + 2, -10, -10, r);
      check("vec_rx_data",     r.rx,                 vecs[i].exp_rx);
      check("vec_valid_at",    r.valid_k,            32'd128);
      check("vec_valid_count", r.nvalid,             32'd1);
      check("vec_sck_rises",   r.nrise,              32'd32);
      check("vec_ss_n_before", {31'd0, r.ssn_pre},   32'd0);
      check("vec_ss_n_at_vld", {31'd0, r.ssn_v},     32'd1);
      check("vec_ready_at_vld",{31'd0, r.rdy_v},     32'd0);
      check("vec_ready_gap",   {31'd0, r.rdy_g},     32'd1);
      check("vec_slave_q",     s_q,                  vecs[i].exp_q);
    end

    // start during a busy frame must be dropped
    loop0 = 1'b1;
    frame(32'hC3C3_3C3C, 2*2*32 + GAP + 2, 10, -10, r);
    check("busy_rx_data",     r.rx,      32'hC3C3_3C3C);
    check("busy_valid_count", r.nvalid,  32'd1);
    check("busy_valid_at",    r.valid_k, 32'd128);

    // reset mid-frame aborts without rx_valid
    frame(32'h5A5A_1234, 2*2*32 + GAP + 2, -10, 40, r);
    check("abort_sck",         {31'd0, r.rs_sck}, 32'd0);
    check("abort_ss_n",        {31'd0, r.rs_ssn}, 32'd1);
    check("abort_ready",       {31'd0, r.rs_rdy}, 32'd1);
    check("abort_rx_data",     r.rs_rx,           32'd0);
    check("abort_valid_count", r.nvalid,          32'd0);
    frame(32'h0F0F_1234, 2*2*32 + GAP + 2, -10, -10, r);
    check("post_abort_rx",     r.rx,      32'h0F0F_1234);
    check("post_abort_at",     r.valid_k, 32'd128);

    // start held high: back-to-back frames separated by IDLE_GAP
    @(negedge clk);
    drive(1'b1, 32'hDEAD_BEEF);
    @(negedge clk);
    drive(1'b1, 32'h0123_4567);
    e0b = -1; nhigh = 0; nv = 0; v2k = -1; rx1 = '0; rx2 = '0;
    for (int k = 1; k <= 270; k++) begin
      @(negedge clk);
      if (m_valid) begin
        nv++;
        if (nv == 1) rx1 = m_rx;
        if (nv == 2) begin rx2 = m_rx; v2k = k; end
      end
      if (nv >= 1 && e0b < 0) begin
        if (m_ss_n) nhigh++;
        else begin
          e0b = k;
          drive(1'b0, 32'h0);
        end
      end
    end
    drive(1'b0, 32'h0);
    check("b2b_rx_first",  rx1,   32'hDEAD_BEEF);
    check("b2b_rx_second", rx2,   32'h0123_4567);
    check("b2b_gap_len",   nhigh, 32'd2);
    check("b2b_second_e0", e0b,   32'd130);
    check("b2b_second_vld",v2k,   32'd258);

    // CLK_DIV=1 instance, loopback
    sel = 1'b1;
    frame(32'h8000_0001, 2*1*32 + GAP + 2, -10, -10, r);
    check("div1_rx_data",     r.rx,             32'h8000_0001);
    check("div1_valid_at",    r.valid_k,        32'd64);
    check("div1_sck_rises",   r.nrise,          32'd32);
    check("div1_valid_count", r.nvalid,         32'd1);
    check("div1_ready_gap",   {31'd0, r.rdy_g}, 32'd1);
    frame(32'h6B6B_9494, 2*1*32 + GAP + 2, -10, -10, r);
    check("div1_rx_data2",    r.rx,             32'h6B6B_9494);
    check("div1_valid_at2",   r.valid_k,        32'd64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
